countdown_timer_bcd: RTL and testbench

//  Parametrised N-digit BCD countdown timer with multiplexed 7-segment drive.

---
 rtl/timer_pkg.sv | 46 ++++
 rtl/bcd_down_digit.sv | 26 ++
 rtl/countdown_timer_bcd.sv | 189 ++++++++++++++++++
 tb/tb_countdown_timer_bcd.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types, 7-segment patterns and BCD helpers for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [3:0] bcd_sanitise(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter; digits chain through borrow_in/borrow_out.
module bcd_down_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
  input  logic       borrow_in,
  input  logic       load,
  input  logic [3:0] load_d,
  output logic [3:0] q,
  output logic       borrow_out
);

  // Asserted when this digit and every lower digit are zero
  assign borrow_out = borrow_in && (q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_d;
    end else if (dec && borrow_in) begin
      q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// N-digit BCD countdown timer: prescaler, run/pause/expire FSM, digit chain
// and a multiplexed 7-segment scanner.
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int TICK_HZ        = 1,
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    mode_wrap,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    running,
  output logic                    done,
  output logic                    expired
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int P     = CLK_FREQ_HZ / TICK_HZ;
  localparam int S_RAW = CLK_FREQ_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int S     = (S_RAW < 1) ? 1 : S_RAW;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int SW    = (S > 1) ? $clog2(S) : 1;
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t              state;
  logic [PW-1:0]       presc;
  logic [W-1:0]        reload_reg;
  logic [W-1:0]        load_clean;
  logic [W-1:0]        digit_load_d;
  logic [NUM_DIGITS:0] borrow;
  logic                tick;
  logic                count_zero;
  logic                count_one;
  logic                digit_load;
  logic                dec;

  always_comb begin
    load_clean = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_clean[4*i +: 4] = bcd_sanitise(load_value[4*i +: 4]);
    end
  end

  // A same-cycle load or pause pre-empts the terminal count
  assign tick         = (state == RUN) && !load && !pause && (presc == PW'(P - 1));
  assign count_zero   = borrow[NUM_DIGITS];
  assign count_one    = (count_bcd == W'(1));
  assign dec          = tick && !count_zero;
  assign digit_load   = load || (tick && count_zero);
  assign digit_load_d = load ? load_clean : reload_reg;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .dec        (dec),
      .borrow_in  (borrow[i]),
      .load       (digit_load),
      .load_d     (digit_load_d[4*i +: 4]),
      .q          (count_bcd[4*i +: 4]),
      .borrow_out (borrow[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      reload_reg <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      expired    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state      <= IDLE;
        reload_reg <= load_clean;
        presc      <= '0;
        running    <= 1'b0;
        expired    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!pause && start && !count_zero) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              presc <= '0;
              // Zero event: normal 1 -> 0 step, or a wrap reload of an all-zero value
              if (count_one || (count_zero && reload_reg == '0)) begin
                done <= 1'b1;
                if (!mode_wrap) begin
                  state   <= EXPIRED;
                  running <= 1'b0;
                  expired <= 1'b1;
                end
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          PAUSE: begin
            if (start && !pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic                  scan_adv;
  logic [NUM_DIGITS-1:0] blank;
  logic                  lead;
  logic [3:0]            sel_digit;
  logic                  sel_blank;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] an_raw;

  assign scan_adv = (scan_cnt == '0);
  assign idx_next = !scan_adv ? idx :
                    (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);

  // Blank a digit only when it and every digit above it are zero
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead     = lead && (count_bcd[4*i +: 4] == 4'd0);
      blank[i] = BLANK_LZ && lead;
    end
  end

  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        sel_digit = count_bcd[4*i +: 4];
        sel_blank = blank[i];
        an_raw[i] = 1'b1;
      end
    end
    seg_raw = sel_blank ? SEG_BLANK : seg_decode(sel_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= SW'(S - 1);
      idx      <= '0;
      seg      <= {7{SEG_ACTIVE_LOW}} ^ SEG_0;
      an       <= {NUM_DIGITS{SEG_ACTIVE_LOW}} ^ NUM_DIGITS'(1);
    end else begin
      scan_cnt <= scan_adv ? SW'(S - 1) : scan_cnt - SW'(1);
      idx      <= idx_next;
      seg      <= {7{SEG_ACTIVE_LOW}} ^ seg_raw;
      an       <= {NUM_DIGITS{SEG_ACTIVE_LOW}} ^ an_raw;
    end
  end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd: P=10 clocks per tick, S=2 clocks per digit.
module tb_countdown_timer_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       mode_wrap = 1'b0;

  logic [7:0] count_bcd, count_lz;
  logic [6:0] seg, seg_lz;
  logic [1:0] an, an_lz;
  logic       running, done, expired;
  logic       running_lz, done_lz, expired_lz;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  countdown_timer_bcd #(
    .CLK_FREQ_HZ(20), .TICK_HZ(2), .NUM_DIGITS(2), .SCAN_HZ(5),
    .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start),
    .pause(pause), .mode_wrap(mode_wrap), .count_bcd(count_bcd), .seg(seg),
    .an(an), .running(running), .done(done), .expired(expired)
  );

  // Second instance: active-high drive with leading-zero blanking
  countdown_timer_bcd #(
    .CLK_FREQ_HZ(20), .TICK_HZ(2), .NUM_DIGITS(2), .SCAN_HZ(5),
    .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)
  ) dut_lz (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start),
    .pause(pause), .mode_wrap(mode_wrap), .count_bcd(count_lz), .seg(seg_lz),
    .an(an_lz), .running(running_lz), .done(done_lz), .expired(expired_lz)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_an;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (count_bcd !== 8'h00 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0)
      begin errors++; $display("FAIL reset_regs: count=%h run=%b done=%b exp=%b, want 00 0 0 0", count_bcd, running, done, expired); end
    checks++;
    if (an !== 2'b10 || seg !== 7'h40)
      begin errors++; $display("FAIL reset_display: an=%b seg=%h, want 10 40", an, seg); end
    checks++;
    if (an_lz !== 2'b01 || seg_lz !== 7'h3F || count_lz !== 8'h00 || running_lz !== 1'b0 || expired_lz !== 1'b0)
      begin errors++; $display("FAIL reset_lz: an=%b seg=%h count=%h, want 01 3f 00", an_lz, seg_lz, count_lz); end
    for (int n = 1; n <= 50; n++) begin
      step();
      exp_an = ((n / 2) % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if (an !== exp_an || seg !== 7'h40 || count_bcd !== 8'h00 || running !== 1'b0)
        begin errors++; $display("FAIL idle_scan n=%0d: an=%b seg=%h count=%h run=%b, want an=%b seg=40 count=00 run=0", n, an, seg, count_bcd, running, exp_an); end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (running !== 1'b0 || count_bcd !== 8'h00)
      begin errors++; $display("FAIL start_at_zero: run=%b count=%h, want 0 00", running, count_bcd); end
  endtask

  task automatic test_countdown();
    int v;
    logic [7:0] exp_c;
    load_value = 8'h12;
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (count_bcd !== 8'h12 || running !== 1'b0)
      begin errors++; $display("FAIL load_12: count=%h run=%b, want 12 0", count_bcd, running); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b1 || count_bcd !== 8'h12)
      begin errors++; $display("FAIL run_entry: run=%b count=%h, want 1 12", running, count_bcd); end
    for (int k = 1; k <= 120; k++) begin
      step();
      v = 12 - k / 10;
      exp_c = {4'(v / 10), 4'(v % 10)};
      checks++;
      if (count_bcd !== exp_c || done !== (k == 120))
        begin errors++; $display("FAIL countdown k=%0d: count=%h done=%b, want %h %b", k, count_bcd, done, exp_c, (k == 120)); end
    end
    checks++;
    if (expired !== 1'b1 || running !== 1'b0)
      begin errors++; $display("FAIL expire: exp=%b run=%b, want 1 0", expired, running); end
    step();
    checks++;
    if (done !== 1'b0)
      begin errors++; $display("FAIL done_width: done=%b, want 0", done); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 15; k++) step();
    checks++;
    if (expired !== 1'b1 || running !== 1'b0 || count_bcd !== 8'h00 || done !== 1'b0)
      begin errors++; $display("FAIL expired_hold: exp=%b run=%b count=%h done=%b, want 1 0 00 0", expired, running, count_bcd, done); end
  endtask

  task automatic test_wrap();
    int v;
    mode_wrap = 1'b1;
    load_value = 8'h03;
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (expired !== 1'b0 || count_bcd !== 8'h03)
      begin errors++; $display("FAIL load_clears_expired: exp=%b count=%h, want 0 03", expired, count_bcd); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      step();
      v = (k < 30) ? 3 - k / 10 : ((k < 40) ? 0 : 3);
      checks++;
      if (count_bcd !== 8'(v) || done !== (k == 30) || running !== 1'b1 || expired !== 1'b0)
        begin errors++; $display("FAIL wrap k=%0d: count=%h done=%b run=%b, want %h %b 1", k, count_bcd, done, running, 8'(v), (k == 30)); end
    end
    mode_wrap = 1'b0;
  endtask

  task automatic test_pause();
    load_value = 8'h05;
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (running !== 1'b0 || count_bcd !== 8'h05)
      begin errors++; $display("FAIL load_from_run: run=%b count=%h, want 0 05", running, count_bcd); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 9 || k == 10) begin
        checks++;
        if (count_bcd !== ((k == 10) ? 8'h04 : 8'h05))
          begin errors++; $display("FAIL pause_pre k=%0d: count=%h, want %h", k, count_bcd, ((k == 10) ? 8'h04 : 8'h05)); end
      end
    end
    pause = 1'b1;
    step();
    checks++;
    if (running !== 1'b0)
      begin errors++; $display("FAIL pause_enter: run=%b, want 0", running); end
    for (int k = 1; k < 40; k++) step();
    checks++;
    if (count_bcd !== 8'h04 || running !== 1'b0)
      begin errors++; $display("FAIL pause_hold: count=%h run=%b, want 04 0", count_bcd, running); end
    pause = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (running !== 1'b1)
      begin errors++; $display("FAIL resume: run=%b, want 1", running); end
    for (int j = 1; j <= 5; j++) begin
      step();
      if (j >= 4) begin
        checks++;
        if (count_bcd !== ((j == 5) ? 8'h03 : 8'h04))
          begin errors++; $display("FAIL partial_period j=%0d: count=%h, want %h", j, count_bcd, ((j == 5) ? 8'h03 : 8'h04)); end
      end
    end
  endtask

  task automatic test_load_sanitise();
    load_value = 8'hAF;
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (count_bcd !== 8'h99 || count_lz !== 8'h99 || running !== 1'b0)
      begin errors++; $display("FAIL sanitise: count=%h lz=%h run=%b, want 99 99 0", count_bcd, count_lz, running); end
    load_value = 8'h23;
    load = 1'b1;
    start = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 15; k++) step();
    checks++;
    if (count_bcd !== 8'h23 || running !== 1'b0)
      begin errors++; $display("FAIL load_beats_start: count=%h run=%b, want 23 0", count_bcd, running); end
  endtask

  task automatic test_reset_mid_run_blank();
    bit seen0, seen1;
    load_value = 8'h08;
    load = 1'b1;
    step();
    load = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) step();
    checks++;
    if (count_bcd !== 8'h07 || running !== 1'b1)
      begin errors++; $display("FAIL pre_reset: count=%h run=%b, want 07 1", count_bcd, running); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (count_bcd !== 8'h00 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0 || an !== 2'b10 || seg !== 7'h40)
      begin errors++; $display("FAIL mid_run_reset: count=%h run=%b done=%b exp=%b an=%b seg=%h, want 00 0 0 0 10 40", count_bcd, running, done, expired, an, seg); end
    load_value = 8'h05;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (an_lz == 2'b10) begin
        seen1 = 1'b1;
        if (seg_lz !== 7'h00)
          begin errors++; $display("FAIL blank_tens: seg=%h, want 00", seg_lz); end
      end else begin
        seen0 = 1'b1;
        if (seg_lz !== 7'h6D)
          begin errors++; $display("FAIL ones_5: seg=%h, want 6d", seg_lz); end
      end
      checks++;
      if (an == 2'b01) begin
        if (seg !== 7'h40)
          begin errors++; $display("FAIL tens_zero_shown: seg=%h, want 40", seg); end
      end else if (seg !== 7'h12)
        begin errors++; $display("FAIL ones_5_low: seg=%h, want 12", seg); end
    end
    checks++;
    if (!(seen0 && seen1))
      begin errors++; $display("FAIL scan_coverage: seen0=%b seen1=%b, want 1 1", seen0, seen1); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_wrap();
    test_pause();
    test_load_sanitise();
    test_reset_mid_run_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
